// File: rtl/bsg_link_traffic_gen_checker.sv
// Closed-loop traffic generator and in-order checker for one ready&valid link.
// Valid/ready contract (both directions): a transfer happens on a rising clock
// edge where valid and ready are both high; once valid is raised it is held,
// with data stable, until that transfer happens.
module bsg_link_traffic_gen_checker #(
  parameter int width_p           = 32,
  parameter int max_outstanding_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  output logic               tx_v_o,
  output logic [width_p-1:0] tx_data_o,
  input  logic               tx_ready_and_i,
  input  logic               rx_v_i,
  input  logic [width_p-1:0] rx_data_i,
  output logic               rx_ready_and_o,
  output logic [31:0]        sent_o,
  output logic [31:0]        received_o,
  output logic               error_o,
  output logic [31:0]        err_seq_o,
  output logic               idle_o
);

  localparam int lanes_lp = width_p / 16;
  localparam int out_w_lp = $clog2(max_outstanding_p + 1);
  localparam logic [out_w_lp:0] max_lp = (out_w_lp + 1)'(max_outstanding_p);

  // Lane k of the payload carries the low 16 bits of the sequence number XOR k.
  function automatic logic [width_p-1:0] pattern(input logic [15:0] n);
    logic [width_p-1:0] p;
    p = '0;
    for (int k = 0; k < lanes_lp; k++) begin
      p[16*k +: 16] = n ^ 16'(k);
    end
    return p;
  endfunction

  logic                tx_v_q, tx_v_d;
  logic [31:0]         tx_seq_q, tx_seq_d;
  logic [31:0]         rx_seq_q, rx_seq_d;
  logic [out_w_lp-1:0] out_q, out_d;
  logic [31:0]         sent_q, sent_d;
  logic [31:0]         received_q, received_d;
  logic                error_q, error_d;
  logic [31:0]         err_seq_q, err_seq_d;
  logic                rx_ready_q;

  logic                tx_hs, rx_hs;
  logic                unexpected, mismatch, rx_err, pend;
  logic [out_w_lp:0]   credit_use;

  assign tx_hs = tx_v_q & tx_ready_and_i;
  assign rx_hs = rx_v_i & rx_ready_q;

  // A packet arriving in the same cycle one is launched (zero-latency loop)
  // is covered by that launch, so it is not counted as unexpected.
  assign unexpected = rx_hs & ~tx_hs & (out_q == '0);
  assign mismatch   = rx_data_i != pattern(rx_seq_q[15:0]);
  assign rx_err     = rx_hs & (mismatch | unexpected);

  // The launched-but-unaccepted packet holds a credit too.
  assign pend       = tx_v_q & ~tx_hs;
  assign credit_use = {1'b0, out_d} + (out_w_lp + 1)'(pend);

  // Next-state computation for counters, credits, arming and error capture.
  always_comb begin
    out_d = out_q;
    if (tx_hs & ~rx_hs) begin
      out_d = out_q + out_w_lp'(1);
    end else if (rx_hs & ~tx_hs & (out_q != '0)) begin
      out_d = out_q - out_w_lp'(1);
    end

    tx_v_d = tx_v_q;
    if (en_i && (credit_use < max_lp)) begin
      tx_v_d = 1'b1;
    end else if (tx_hs) begin
      tx_v_d = 1'b0;
    end

    tx_seq_d   = tx_seq_q + 32'(tx_hs);
    sent_d     = sent_q + 32'(tx_hs);
    rx_seq_d   = rx_seq_q + 32'(rx_hs);
    received_d = received_q + 32'(rx_hs);

    error_d   = error_q;
    err_seq_d = err_seq_q;
    if (rx_err && !error_q) begin
      error_d   = 1'b1;
      err_seq_d = rx_seq_q;
    end
  end

  // State registers; reset clears everything at once without a clock edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      tx_v_q     <= 1'b0;
      tx_seq_q   <= '0;
      rx_seq_q   <= '0;
      out_q      <= '0;
      sent_q     <= '0;
      received_q <= '0;
      error_q    <= 1'b0;
      err_seq_q  <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      tx_v_q     <= tx_v_d;
      tx_seq_q   <= tx_seq_d;
      rx_seq_q   <= rx_seq_d;
      out_q      <= out_d;
      sent_q     <= sent_d;
      received_q <= received_d;
      error_q    <= error_d;
      err_seq_q  <= err_seq_d;
      rx_ready_q <= 1'b1;
    end
  end

  assign tx_v_o         = tx_v_q;
  assign tx_data_o      = pattern(tx_seq_q[15:0]);
  assign rx_ready_and_o = rx_ready_q;
  assign sent_o         = sent_q;
  assign received_o     = received_q;
  assign error_o        = error_q;
  assign err_seq_o      = err_seq_q;
  assign idle_o         = ~tx_v_q & (out_q == '0);

endmodule

// File: tb/tb_bsg_link_traffic_gen_checker.sv
// Bench for bsg_link_traffic_gen_checker: loopback, FIFO link with random
// backpressure, credit bound, corruption, unexpected packet, en drop, reset.
module tb_bsg_link_traffic_gen_checker;

  localparam int W   = 32;
  localparam int MAX = 8;
  localparam int M_DIR  = 0;
  localparam int M_LOOP = 1;
  localparam int M_FIFO = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i;
  logic          en_i;
  logic          tx_v_o;
  logic [W-1:0]  tx_data_o;
  logic          tx_ready_and_i;
  logic          rx_v_i;
  logic [W-1:0]  rx_data_i;
  logic          rx_ready_and_o;
  logic [31:0]   sent_o, received_o, err_seq_o;
  logic          error_o, idle_o;

  int            mode;
  logic          drv_tx_ready, drv_rx_v;
  logic [W-1:0]  drv_rx_data;

  assign tx_ready_and_i = (mode == M_LOOP) ? rx_ready_and_o : drv_tx_ready;
  assign rx_v_i         = (mode == M_LOOP) ? tx_v_o         : drv_rx_v;
  assign rx_data_i      = (mode == M_LOOP) ? tx_data_o      : drv_rx_data;

  bsg_link_traffic_gen_checker #(.width_p(W), .max_outstanding_p(MAX)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .en_i           (en_i),
    .tx_v_o         (tx_v_o),
    .tx_data_o      (tx_data_o),
    .tx_ready_and_i (tx_ready_and_i),
    .rx_v_i         (rx_v_i),
    .rx_data_i      (rx_data_i),
    .rx_ready_and_o (rx_ready_and_o),
    .sent_o         (sent_o),
    .received_o     (received_o),
    .error_o        (error_o),
    .err_seq_o      (err_seq_o),
    .idle_o         (idle_o)
  );

  // link FIFO used in M_FIFO mode
  logic [W-1:0] link_q[$];
  int           depth     = 4;
  int           ready_pct = 100;
  logic         rx_allow  = 1'b1;
  logic [31:0]  c_seq1    = 32'hffff_ffff;
  logic [31:0]  c_seq2    = 32'hffff_ffff;

  // scoreboard: expected in-flight payloads plus reference counters
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_sent, m_recv, m_rx_seq, m_err_seq;
  logic         m_err, m_txv;
  logic         pend_prev;
  logic [W-1:0] prev_data;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [W-1:0] pat(input logic [31:0] n);
    logic [W-1:0] p;
    p = '0;
    for (int k = 0; k < W / 16; k++) p[16*k +: 16] = n[15:0] ^ 16'(k);
    return p;
  endfunction

  function automatic logic [W-1:0] cmask(input logic [31:0] s);
    logic [W-1:0] m;
    m = '0;
    if (s == c_seq1 || s == c_seq2) m[20] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    link_q.delete();
    m_sent = 0; m_recv = 0; m_rx_seq = 0; m_err_seq = 0;
    m_err = 1'b0; m_txv = 1'b0; pend_prev = 1'b0; prev_data = '0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_tx_v"},     tx_v_o, 0);
    chk({pfx, "_rx_ready"}, rx_ready_and_o, 0);
    chk({pfx, "_sent"},     sent_o, 0);
    chk({pfx, "_received"}, received_o, 0);
    chk({pfx, "_error"},    error_o, 0);
    chk({pfx, "_err_seq"},  err_seq_o, 0);
    chk({pfx, "_idle"},     idle_o, 1);
    chk({pfx, "_tx_data"},  tx_data_o, pat(0));
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    en_i = 1'b0;
    mode = M_DIR;
    drv_tx_ready = 1'b0; drv_rx_v = 1'b0; drv_rx_data = '0;
    c_seq1 = 32'hffff_ffff; c_seq2 = 32'hffff_ffff;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    reset_i = 1'b0;
  endtask

  // driver: one clock cycle, entered and left just after a falling edge
  task automatic cycle();
    logic c_tx_v, c_tx_rdy, c_rx_v, c_rx_rdy, c_en, tx_hs, rx_hs, bad;
    logic [W-1:0] c_tx_data, c_rx_data;
    if (mode == M_FIFO) begin
      drv_rx_v     = rx_allow && (link_q.size() > 0);
      drv_rx_data  = (link_q.size() > 0) ? (link_q[0] ^ cmask(m_rx_seq)) : '0;
      drv_tx_ready = (link_q.size() < depth) && ($urandom_range(0, 99) < ready_pct);
    end
    #1;
    c_tx_v = tx_v_o; c_tx_rdy = tx_ready_and_i; c_tx_data = tx_data_o;
    c_rx_v = rx_v_i; c_rx_rdy = rx_ready_and_o; c_rx_data = rx_data_i;
    c_en = en_i;
    if (pend_prev) begin
      chk("tx_v_hold", c_tx_v, 1);
      chk("tx_data_hold", c_tx_data, prev_data);
    end
    tx_hs = c_tx_v && c_tx_rdy;
    rx_hs = c_rx_v && c_rx_rdy;
    if (tx_hs) chk("tx_payload", c_tx_data, pat(m_sent));
    pend_prev = c_tx_v && !c_tx_rdy;
    prev_data = c_tx_data;
    @(posedge clk);
    // reference model update from the sampled handshakes
    if (tx_hs) begin
      exp_q.push_back(c_tx_data);
      m_sent++;
    end
    if (rx_hs) begin
      bad = (c_rx_data !== pat(m_rx_seq));
      if (exp_q.size() == 0) bad = 1'b1;
      else void'(exp_q.pop_front());
      if (bad && !m_err) begin
        m_err = 1'b1;
        m_err_seq = m_rx_seq;
      end
      m_rx_seq++;
      m_recv++;
    end
    if (c_en && (exp_q.size() + ((m_txv && !tx_hs) ? 1 : 0)) < MAX) m_txv = 1'b1;
    else if (tx_hs) m_txv = 1'b0;
    if (mode == M_FIFO) begin
      if (rx_hs) void'(link_q.pop_front());
      if (tx_hs) link_q.push_back(c_tx_data);
    end
    @(negedge clk);
    chk("sent", sent_o, m_sent);
    chk("received", received_o, m_recv);
    chk("error", error_o, m_err);
    chk("err_seq", err_seq_o, m_err_seq);
    chk("tx_v", tx_v_o, m_txv);
    chk("idle", idle_o, (!m_txv && exp_q.size() == 0));
    chk("rx_ready", rx_ready_and_o, 1);
    chk("out_bound", (exp_q.size() <= MAX), 1);
  endtask

  task automatic drain();
    en_i = 1'b0;
    ready_pct = 100;
    rx_allow = 1'b1;
    for (int i = 0; i < 200 && !(exp_q.size() == 0 && !m_txv); i++) cycle();
    chk("drain_done", (exp_q.size() == 0 && !m_txv), 1);
  endtask

  initial begin
    reset_i = 1'b1; en_i = 1'b0; mode = M_DIR;
    drv_tx_ready = 1'b0; drv_rx_v = 1'b0; drv_rx_data = '0;
    model_clear();

    // 1. reset values, then zero-latency loopback
    do_reset();
    mode = M_LOOP;
    en_i = 1'b1;
    for (int i = 0; i < 100; i++) cycle();
    en_i = 1'b0;
    cycle();
    drain();
    chk("loop_sent", sent_o, 100);
    chk("loop_equal", (sent_o == received_o), 1);
    chk("loop_error", error_o, 0);
    chk("loop_idle", idle_o, 1);

    // 2. random backpressure through a 4-deep FIFO
    do_reset();
    mode = M_FIFO; depth = 4; ready_pct = 50;
    en_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rx_allow = 1'($urandom_range(0, 1));
      cycle();
    end
    drain();
    chk("bp_equal", (sent_o == received_o), 1);
    chk("bp_error", error_o, 0);
    chk("bp_some_traffic", (sent_o > 20), 1);

    // 3. credit bound with the return path blocked
    do_reset();
    mode = M_FIFO; depth = 16; ready_pct = 100; rx_allow = 1'b0;
    en_i = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("credit_sent", sent_o, MAX);
    chk("credit_tx_v", tx_v_o, 0);
    rx_allow = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("credit_returned", (received_o >= MAX), 1);
    chk("credit_resumed", (sent_o > MAX), 1);
    drain();
    chk("credit_equal", (sent_o == received_o), 1);
    chk("credit_error", error_o, 0);

    // 4. corruption of sequence 5 and later 9
    do_reset();
    mode = M_FIFO; depth = 4; ready_pct = 100; rx_allow = 1'b1;
    c_seq1 = 32'd5; c_seq2 = 32'd9;
    en_i = 1'b1;
    for (int i = 0; i < 40; i++) cycle();
    drain();
    chk("corrupt_error", error_o, 1);
    chk("corrupt_err_seq", err_seq_o, 5);

    // 5. unexpected packet with nothing in flight
    do_reset();
    cycle();
    drv_rx_v = 1'b1; drv_rx_data = pat(0);
    cycle();
    drv_rx_v = 1'b0;
    cycle();
    chk("unexp_error", error_o, 1);
    chk("unexp_err_seq", err_seq_o, 0);
    chk("unexp_received", received_o, 1);
    chk("unexp_idle", idle_o, 1);

    // 6. en dropped while valid is pending
    do_reset();
    drv_tx_ready = 1'b0;
    en_i = 1'b1;
    cycle();
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("endrop_hold", tx_v_o, 1);
    end
    drv_tx_ready = 1'b1;
    cycle();
    drv_tx_ready = 1'b0;
    chk("endrop_fall", tx_v_o, 0);
    chk("endrop_sent", sent_o, 1);
    drv_rx_v = 1'b1; drv_rx_data = pat(0);
    cycle();
    drv_rx_v = 1'b0;
    chk("endrop_idle", idle_o, 1);
    chk("endrop_error", error_o, 0);

    // 7. asynchronous reset mid-stream
    do_reset();
    mode = M_FIFO; depth = 4; ready_pct = 100; rx_allow = 1'b1;
    en_i = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    #2 reset_i = 1'b1;
    #1 chk_reset_vals("async");
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
